// File: rtl/avalon_mem_slave_if.sv
// Avalon-MM request/response bundle between a bus master and a memory slave.
// The slave drives only readdata and waitrequest.
interface avalon_mem_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write,
        output writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write,
        input  writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave RAM with fixed or LFSR-random wait states,
// sticky error capture and a side-band debug read port.
module avalon_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    avalon_mem_slave_if.slave bus,
    output logic              err,
    output logic [31:0]       err_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam int unsigned WMOD = WAIT_CYCLES + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [15:0]       r_lfsr;
    logic [31:0]       r_addr;
    logic              r_rd;
    logic              r_wr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_word;
    logic              r_bad;
    logic              r_err;
    logic [31:0]       r_err_addr;
    logic [31:0]       r_mem [2**ADDR_W];

    logic [31:0] w_off;
    logic [31:0] w_word;
    logic        w_oor;
    logic        w_mis;
    logic        w_bad;
    logic        w_req;
    logic        w_same;
    logic [31:0] w_rand;
    logic [3:0]  w_wait;
    logic [15:0] w_lfsr_nxt;
    logic        w_accept;
    logic        w_perr;
    logic        w_we;

    assign w_off  = bus.address - BASE_ADDR;
    assign w_word = w_off >> 2;
    assign w_oor  = (bus.address < BASE_ADDR)
                  | (|w_word[31:ADDR_W]);
    assign w_mis  = |bus.address[1:0];
    assign w_bad  = w_oor | w_mis
                  | (bus.read & bus.write);
    assign w_req  = bus.read | bus.write;

    // The master must hold every request field while we stall.
    assign w_same = (bus.read == r_rd)
                  && (bus.write == r_wr)
                  && (bus.address == r_addr)
                  && (bus.writedata == r_wdata)
                  && (bus.byteenable == r_be);

    assign w_rand = 32'(r_lfsr[3:0]) % WMOD;
    assign w_wait = RANDOM_WAIT ? w_rand[3:0]
                                : 4'(WAIT_CYCLES);

    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                      ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_perr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = w_wait;
                    w_state_nxt = (w_wait == 4'd0) ? S_ACK
                                                   : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_same) begin
                    w_perr      = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_lfsr     <= LFSR_SEED;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_word     <= '0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= bus.address;
                r_rd    <= bus.read;
                r_wr    <= bus.write;
                r_wdata <= bus.writedata;
                r_be    <= bus.byteenable;
                r_word  <= w_word[ADDR_W-1:0];
                r_bad   <= w_bad;
            end
            if (RANDOM_WAIT && w_accept) begin
                r_lfsr <= w_lfsr_nxt;
            end
            if (!r_err && ((w_accept && w_bad) || w_perr)) begin
                r_err      <= 1'b1;
                r_err_addr <= w_perr ? r_addr : bus.address;
            end
        end
    end

    // Only a clean write commits, at the edge that closes ACK.
    assign w_we = (r_state == S_ACK) && r_wr && !r_bad;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.waitrequest = (r_state != S_ACK);
    assign bus.readdata    = (r_state != S_ACK) ? 32'h0
                           : r_bad ? 32'hDEADBEEF
                           : r_mem[r_word];
    assign err       = r_err;
    assign err_addr  = r_err_addr;
    assign dbg_rdata = r_mem[dbg_addr];

endmodule
